// File: rtl/sha1_pad.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sha1_pad : SHA-1 message padder, 32-bit word stream in, 512-bit blocks out.
// Build option: define SHA1_PAD_BSWAP_EN for little-endian input words.
// Revision : 1.0
// ----------------------------------------------------------------------------
module sha1_pad #(
  parameter int LEN_W     = 64,
  parameter int ZERO_FILL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);
  // Only the low 61 count bits can ever reach the 64-bit length field.
  localparam int CNT_W = (LEN_W > 61) ? 61 : LEN_W;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_EMIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [511:0]       buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               first_q, first_d;
  logic               mark_q, mark_d;        // 0x80 word still owed
  logic               nolen_q, nolen_d;      // current block has no room for length
  logic               pad_q, pad_d;          // another pad-only block follows emit
  logic               lastblk_q, lastblk_d;

  logic [31:0]        w_word;
  logic [2:0]         w_n;
  logic [31:0]        w_tail;
  logic [63:0]        w_len;
  logic [8:0]         w_off;
  logic               w_nolen;
  logic [31:0]        w_pad_word;

`ifdef SHA1_PAD_BSWAP_EN
  assign w_word = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
  assign w_word = in_data;
`endif

  assign w_n   = (!in_last || (in_nbytes > 3'd4)) ? 3'd4 : in_nbytes;
  assign w_len = 64'({cnt_q, 3'b000});
  assign w_off = {4'd15 - idx_q, 5'd0};

  always_comb begin
    w_tail = w_word;
    case (w_n)
      3'd0:    w_tail = 32'h8000_0000;
      3'd1:    w_tail = {w_word[31:24], 8'h80, 16'h0000};
      3'd2:    w_tail = {w_word[31:16], 8'h80, 8'h00};
      3'd3:    w_tail = {w_word[31:8], 8'h80};
      default: w_tail = w_word;
    endcase
  end

  // A marker written at word 14 or 15 pushes the length into the next block.
  assign w_nolen = mark_q ? (idx_q >= 4'd14) : nolen_q;

  always_comb begin
    w_pad_word = (ZERO_FILL != 0) ? 32'h0 : buf_q[w_off +: 32];
    if (mark_q)
      w_pad_word = 32'h8000_0000;
    else if ((idx_q == 4'd14) && !w_nolen)
      w_pad_word = w_len[63:32];
    else if ((idx_q == 4'd15) && !w_nolen)
      w_pad_word = w_len[31:0];
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    mark_d    = mark_q;
    nolen_d   = nolen_q;
    pad_d     = pad_q;
    lastblk_d = lastblk_q;
    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          buf_d[w_off +: 32] = in_last ? w_tail : w_word;
          cnt_d = cnt_q + CNT_W'(w_n);
          idx_d = idx_q + 4'd1;
          if (!in_last) begin
            if (idx_q == 4'd15) begin
              state_d   = S_EMIT;
              lastblk_d = 1'b0;
              pad_d     = 1'b0;
            end
          end else begin
            mark_d = (w_n == 3'd4);
            if (idx_q == 4'd15) begin
              state_d   = S_EMIT;
              lastblk_d = 1'b0;
              pad_d     = 1'b1;
              nolen_d   = 1'b0;
            end else begin
              state_d = S_PAD;
              nolen_d = (w_n != 3'd4) && (idx_q == 4'd14);
            end
          end
        end
      end
      S_PAD: begin
        buf_d[w_off +: 32] = w_pad_word;
        mark_d  = 1'b0;
        nolen_d = w_nolen;
        idx_d   = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d   = S_EMIT;
          lastblk_d = !w_nolen;
          pad_d     = w_nolen;
        end
      end
      S_EMIT: begin
        if (blk_ready) begin
          idx_d   = 4'd0;
          first_d = 1'b0;
          if (pad_q) begin
            state_d = S_PAD;
            pad_d   = 1'b0;
            nolen_d = 1'b0;
          end else begin
            state_d = S_FILL;
          end
          if (lastblk_q) begin
            cnt_d   = '0;
            first_d = 1'b1;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FILL;
      idx_q     <= '0;
      buf_q     <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b1;
      mark_q    <= 1'b0;
      nolen_q   <= 1'b0;
      pad_q     <= 1'b0;
      lastblk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      mark_q    <= mark_d;
      nolen_q   <= nolen_d;
      pad_q     <= pad_d;
      lastblk_q <= lastblk_d;
    end
  end

  assign in_ready  = (state_q == S_FILL) && !rst;
  assign blk_valid = (state_q == S_EMIT);
  assign blk_data  = buf_q;
  assign blk_first = (state_q == S_EMIT) && first_q;
  assign blk_last  = (state_q == S_EMIT) && lastblk_q;

endmodule
`default_nettype wire

// File: tb/tb_sha1_pad.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sha1_pad : self-checking bench for sha1_pad against a byte-level padding model.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_sha1_pad;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  always #5 clk = ~clk;

  sha1_pad dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  typedef struct {
    int          len;
    logic [7:0]  base;
    int          nblk;
    logic [31:0] w0;
    logic [31:0] w15;
  } vec_t;

  blk_t exp_q[$];
  blk_t got_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic summary_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  task automatic check(input string nm, input logic [511:0] got, input logic [511:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  task automatic abort(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", nm);
    summary_and_finish();
  endtask

  function automatic logic [31:0] pack(input logic [31:0] be);
`ifdef SHA1_PAD_BSWAP_EN
    return {be[7:0], be[15:8], be[23:16], be[31:24]};
`else
    return be;
`endif
  endfunction

  // Reference: FIPS 180-4 padding on a byte list, then cut into 64-byte blocks.
  function automatic void build_exp(input logic [7:0] msg[$]);
    logic [7:0]  p[$];
    logic [63:0] bits;
    int          nb;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nb = p.size() / 64;
    exp_q.delete();
    for (int b = 0; b < nb; b++) begin
      blk_t e;
      e.data = '0;
      for (int i = 0; i < 64; i++) e.data[511-8*i -: 8] = p[64*b+i];
      e.first = (b == 0);
      e.last  = (b == nb - 1);
      exp_q.push_back(e);
    end
  endfunction

  task automatic put_word(input logic [31:0] d, input bit last, input int nb);
    int t;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    in_nbytes = last ? 3'(nb) : 3'($urandom_range(0, 7));
    t = 0;
    while (!in_ready) begin
      @(negedge clk);
      t++;
      if (t > 4000) abort("in_ready_wait");
    end
    @(posedge clk);
  endtask

  task automatic send_msg(input logic [7:0] msg[$]);
    int          nw;
    int          nb;
    logic [31:0] d;
    nw = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      nb = msg.size() - 4 * w;
      if (nb > 4) nb = 4;
      d = $urandom;
      for (int k = 0; k < nb; k++) d[31-8*k -: 8] = msg[4*w+k];
      put_word(pack(d), (w == nw - 1), nb);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv_blocks(input bit rnd);
    int   n;
    int   t;
    blk_t g;
    n = exp_q.size();
    for (int b = 0; b < n; b++) begin
      t = 0;
      forever begin
        @(negedge clk);
        blk_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (blk_valid && blk_ready) break;
        t++;
        if (t > 4000) abort("blk_valid_wait");
      end
      check("blk_data", blk_data, exp_q[b].data);
      check("blk_first", blk_first, exp_q[b].first);
      check("blk_last", blk_last, exp_q[b].last);
      g.data  = blk_data;
      g.first = blk_first;
      g.last  = blk_last;
      got_q.push_back(g);
    end
  endtask

  task automatic run_msg(input logic [7:0] msg[$], input bit rnd);
    build_exp(msg);
    got_q.delete();
    fork
      send_msg(msg);
      recv_blocks(rnd);
    join
    @(negedge clk);
    blk_ready = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int t;
    t = 0;
    while (!blk_valid) begin
      @(negedge clk);
      t++;
      if (t > 2000) abort(nm);
    end
  endtask

  vec_t       vecs[13];
  logic [7:0] m[$];
  int         cyc;

  initial begin
    vecs[0]  = '{0,   8'h00, 1, 32'h8000_0000, 32'h0000_0000};
    vecs[1]  = '{3,   8'h61, 1, 32'h6162_6380, 32'h0000_0018};
    vecs[2]  = '{1,   8'h41, 1, 32'h4180_0000, 32'h0000_0008};
    vecs[3]  = '{2,   8'h41, 1, 32'h4142_8000, 32'h0000_0010};
    vecs[4]  = '{4,   8'h31, 1, 32'h3132_3334, 32'h0000_0020};
    vecs[5]  = '{55,  8'h10, 1, 32'h1011_1213, 32'h0000_01B8};
    vecs[6]  = '{56,  8'h10, 2, 32'h1011_1213, 32'h0000_01C0};
    vecs[7]  = '{58,  8'h10, 2, 32'h1011_1213, 32'h0000_01D0};
    vecs[8]  = '{60,  8'h10, 2, 32'h1011_1213, 32'h0000_01E0};
    vecs[9]  = '{63,  8'h10, 2, 32'h1011_1213, 32'h0000_01F8};
    vecs[10] = '{64,  8'h10, 2, 32'h1011_1213, 32'h0000_0200};
    vecs[11] = '{119, 8'h00, 2, 32'h0001_0203, 32'h0000_03B8};
    vecs[12] = '{120, 8'h00, 3, 32'h0001_0203, 32'h0000_03C0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_nbytes = '0;
    blk_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_blk_valid", blk_valid, 1'b0);
    check("rst_blk_data", blk_data, 512'h0);
    check("rst_blk_first", blk_first, 1'b0);
    check("rst_blk_last", blk_last, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // "abc" latency: handshake in cycle 0, blk_valid expected in cycle 16
    m = '{8'h61, 8'h62, 8'h63};
    build_exp(m);
    put_word(pack(32'h6162_6300), 1'b1, 3);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!blk_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("abc_latency", cyc, 16);
    check("abc_data", blk_data, exp_q[0].data);
    check("abc_first", blk_first, 1'b1);
    check("abc_last", blk_last, 1'b1);
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;

    for (int v = 0; v < 13; v++) begin
      m.delete();
      for (int i = 0; i < vecs[v].len; i++) m.push_back(vecs[v].base + 8'(i));
      run_msg(m, 1'b0);
      check("tbl_nblk", got_q.size(), vecs[v].nblk);
      if (got_q.size() > 0) begin
        check("tbl_w0", got_q[0].data[511:480], vecs[v].w0);
        check("tbl_w15", got_q[got_q.size()-1].data[31:0], vecs[v].w15);
      end
    end

    // Backpressure on a two-block message (14 words, last word full)
    m.delete();
    for (int w = 0; w < 14; w++) begin
      m.push_back(8'h31); m.push_back(8'h32); m.push_back(8'h33); m.push_back(8'h34);
    end
    build_exp(m);
    blk_ready = 1'b0;
    for (int w = 0; w < 14; w++) put_word(pack(32'h3132_3334), (w == 13), 4);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid("bp_wait1");
    check("bp_data1", blk_data, exp_q[0].data);
    check("bp_w14", blk_data[63:32], 32'h8000_0000);
    check("bp_first1", blk_first, 1'b1);
    check("bp_last1", blk_last, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold_valid", blk_valid, 1'b1);
      check("bp_hold_data", blk_data, exp_q[0].data);
      check("bp_hold_inready", in_ready, 1'b0);
    end
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    check("bp_one_retired", blk_valid, 1'b0);
    wait_valid("bp_wait2");
    check("bp_data2", blk_data, exp_q[1].data);
    check("bp_w15", blk_data[31:0], 32'h0000_01C0);
    check("bp_first2", blk_first, 1'b0);
    check("bp_last2", blk_last, 1'b1);
    repeat (3) @(negedge clk);
    check("bp_blk2_held", blk_valid, 1'b1);
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    check("bp_done_valid", blk_valid, 1'b0);
    check("bp_done_inready", in_ready, 1'b1);

    // Back-to-back messages: counter and first flag restart
    m = '{8'h31, 8'h32, 8'h33, 8'h34};
    run_msg(m, 1'b0);
    m = '{8'h41, 8'h42, 8'h43, 8'h44};
    run_msg(m, 1'b0);
    check("b2b_nblk", got_q.size(), 1);
    check("b2b_first", got_q[0].first, 1'b1);
    check("b2b_len", got_q[0].data[31:0], 32'h0000_0020);

    // Reset in the middle of PAD
    put_word(pack(32'h6162_6300), 1'b1, 3);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_inready", in_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midpad_rst_valid", blk_valid, 1'b0);
    check("midpad_rst_inready", in_ready, 1'b1);
    m = '{8'h61, 8'h62};
    run_msg(m, 1'b0);
    check("post_rst_len", got_q[0].data[31:0], 32'h0000_0010);

    // Reset while a block is pending in EMIT
    put_word(pack(32'h6100_0000), 1'b1, 1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid("emit_rst_wait");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("emit_rst_valid", blk_valid, 1'b0);
    check("emit_rst_data", blk_data, 512'h0);

    // Randomized messages with random downstream stalls
    for (int r = 0; r < 25; r++) begin
      int len;
      len = $urandom_range(0, 140);
      m.delete();
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      run_msg(m, 1'b1);
    end

    summary_and_finish();
  end

endmodule
`default_nettype wire
